// File: rtl/vga_timing_gen.sv
// VGA raster timing: a clock divider makes the pixel strobe, and the pixel
// counters drive registered sync, blanking and line/frame start pulses.
module vga_timing_gen #(
    parameter int CLK_DIV  = 2,
    parameter int H_VIS    = 800,
    parameter int H_FP     = 56,
    parameter int H_SYNC   = 120,
    parameter int H_BP     = 64,
    parameter int V_VIS    = 600,
    parameter int V_FP     = 37,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 23,
    parameter int SYNC_POL = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        pix_en,
    output logic [10:0] Hcnt,
    output logic [10:0] Vcnt,
    output logic        hs,
    output logic        vs,
    output logic        video_on,
    output logic        line_start,
    output logic        frame_start
);
    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOTAL > 2048 || V_TOTAL > 2048 || CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_cfg
            $error("vga_timing_gen: illegal timing parameters");
        end
    endgenerate

    localparam logic [3:0]  DIV_MAX = 4'(CLK_DIV - 1);
    localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST  = 11'(V_TOTAL - 1);
    localparam logic [11:0] H_VIS_W = 12'(H_VIS);
    localparam logic [11:0] V_VIS_W = 12'(V_VIS);
    localparam logic [11:0] HS_BEG  = 12'(H_VIS + H_FP);
    localparam logic [11:0] HS_END  = 12'(H_VIS + H_FP + H_SYNC);
    localparam logic [11:0] VS_BEG  = 12'(V_VIS + V_FP);
    localparam logic [11:0] VS_END  = 12'(V_VIS + V_FP + V_SYNC);
    localparam logic        ACT     = (SYNC_POL != 0);

    // Half-open window test; widened to 12 bits so a 2048 bound still fits.
    function automatic logic in_win(input logic [10:0] c, input logic [11:0] lo,
                                    input logic [11:0] hi);
        return ({1'b0, c} >= lo) && ({1'b0, c} < hi);
    endfunction

    logic [3:0]  div, div_nxt;
    logic [10:0] h_nxt, v_nxt;
    logic        started, started_nxt;

    always_comb begin
        div_nxt = (div == DIV_MAX) ? 4'd0 : div + 4'd1;
    end

    // The first strobe after reset only arms the raster, so 0,0 lasts a full pixel.
    always_comb begin
        h_nxt       = Hcnt;
        v_nxt       = Vcnt;
        started_nxt = started;
        if (pix_en) begin
            if (!started) begin
                started_nxt = 1'b1;
            end else if (Hcnt == H_LAST) begin
                h_nxt = 11'd0;
                v_nxt = (Vcnt == V_LAST) ? 11'd0 : Vcnt + 11'd1;
            end else begin
                h_nxt = Hcnt + 11'd1;
            end
        end
    end

    // Decode from next-state values so the flags land with the counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div         <= 4'd0;
            pix_en      <= 1'b0;
            Hcnt        <= 11'd0;
            Vcnt        <= 11'd0;
            started     <= 1'b0;
            hs          <= ~ACT;
            vs          <= ~ACT;
            video_on    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            div         <= div_nxt;
            pix_en      <= (div_nxt == DIV_MAX);
            Hcnt        <= h_nxt;
            Vcnt        <= v_nxt;
            started     <= started_nxt;
            hs          <= in_win(h_nxt, HS_BEG, HS_END) ? ACT : ~ACT;
            vs          <= in_win(v_nxt, VS_BEG, VS_END) ? ACT : ~ACT;
            video_on    <= started_nxt && in_win(h_nxt, 12'd0, H_VIS_W)
                                       && in_win(v_nxt, 12'd0, V_VIS_W);
            line_start  <= pix_en && (h_nxt == 11'd0);
            frame_start <= pix_en && (h_nxt == 11'd0) && (v_nxt == 11'd0);
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: four timing configurations share one clock and reset; outputs are
// compared every cycle against an arithmetic raster model.
module tb_vga_timing_gen;
    typedef struct packed {
        logic        pe;
        logic [10:0] h;
        logic [10:0] v;
        logic        hs;
        logic        vs;
        logic        vid;
        logic        ls;
        logic        fs;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   ncyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   phase = 0;
    int   a_hs_cnt = 0, a_vid_cnt = 0, b_vs_cnt = 0;

    always #5 clk = ~clk;

    // Posedges since the last reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ncyc <= 0;
        else        ncyc <= ncyc + 1;
    end

    logic        pe_a, hs_a, vs_a, vid_a, ls_a, fs_a; logic [10:0] h_a, v_a;
    logic        pe_b, hs_b, vs_b, vid_b, ls_b, fs_b; logic [10:0] h_b, v_b;
    logic        pe_c, hs_c, vs_c, vid_c, ls_c, fs_c; logic [10:0] h_c, v_c;
    logic        pe_e, hs_e, vs_e, vid_e, ls_e, fs_e; logic [10:0] h_e, v_e;
    obs_t oa, ob, oc, oe;
    assign oa = {pe_a, h_a, v_a, hs_a, vs_a, vid_a, ls_a, fs_a};
    assign ob = {pe_b, h_b, v_b, hs_b, vs_b, vid_b, ls_b, fs_b};
    assign oc = {pe_c, h_c, v_c, hs_c, vs_c, vid_c, ls_c, fs_c};
    assign oe = {pe_e, h_e, v_e, hs_e, vs_e, vid_e, ls_e, fs_e};

    vga_timing_gen dut_a (
        .clk(clk), .rst_n(rst_n), .pix_en(pe_a), .Hcnt(h_a), .Vcnt(v_a),
        .hs(hs_a), .vs(vs_a), .video_on(vid_a), .line_start(ls_a), .frame_start(fs_a));

    vga_timing_gen #(.CLK_DIV(1), .H_VIS(10), .H_FP(2), .H_SYNC(3), .H_BP(2),
                     .V_VIS(5), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .pix_en(pe_b), .Hcnt(h_b), .Vcnt(v_b),
        .hs(hs_b), .vs(vs_b), .video_on(vid_b), .line_start(ls_b), .frame_start(fs_b));

    vga_timing_gen #(.CLK_DIV(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .pix_en(pe_c), .Hcnt(h_c), .Vcnt(v_c),
        .hs(hs_c), .vs(vs_c), .video_on(vid_c), .line_start(ls_c), .frame_start(fs_c));

    vga_timing_gen #(.CLK_DIV(3), .H_VIS(6), .H_FP(1), .H_SYNC(2), .H_BP(1),
                     .V_VIS(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1)) dut_e (
        .clk(clk), .rst_n(rst_n), .pix_en(pe_e), .Hcnt(h_e), .Vcnt(v_e),
        .hs(hs_e), .vs(vs_e), .video_on(vid_e), .line_start(ls_e), .frame_start(fs_e));

    // Raster state after m clock edges since release: pixel strobes land on
    // edges m = D, 2D, ... (from edge 2 when D = 1); the first only starts the
    // raster, every later one advances the pixel position by one.
    function automatic obs_t model(input int d, input int hv, input int hf, input int hsw,
                                   input int hb, input int vv, input int vf, input int vsw,
                                   input int vb, input int pol, input int m);
        obs_t o;
        int ht, vt, k, p, hh, vl;
        logic st, pl, pix_edge;
        ht = hv + hf + hsw + hb;
        vt = vv + vf + vsw + vb;
        k  = m / d;
        if (d == 1 && k > 0) k = k - 1;
        st = (k > 0);
        p  = st ? k - 1 : 0;
        hh = p % ht;
        vl = (p / ht) % vt;
        pl = (pol != 0);
        pix_edge = (m >= 2) && (m % d == 0);
        o.pe  = (m >= 1) && (m % d == d - 1);
        o.h   = 11'(hh);
        o.v   = 11'(vl);
        o.hs  = (hh >= hv + hf && hh < hv + hf + hsw) ? pl : !pl;
        o.vs  = (vl >= vv + vf && vl < vv + vf + vsw) ? pl : !pl;
        o.vid = st && hh < hv && vl < vv;
        o.ls  = pix_edge && hh == 0;
        o.fs  = pix_edge && hh == 0 && vl == 0;
        return o;
    endfunction

    function automatic obs_t m_a(input int m); return model(2, 800, 56, 120, 64, 600, 37, 6, 23, 1, m); endfunction
    function automatic obs_t m_b(input int m); return model(1, 10, 2, 3, 2, 5, 1, 2, 1, 0, m); endfunction
    function automatic obs_t m_c(input int m); return model(4, 800, 56, 120, 64, 600, 37, 6, 23, 1, m); endfunction
    function automatic obs_t m_e(input int m); return model(3, 6, 1, 2, 1, 4, 1, 1, 1, 1, m); endfunction

    task automatic chk(input string nm, input obs_t exp, input obs_t act);
        checks++;
        if (exp !== act) begin
            failures++;
            $display("FAIL %s m=%0d got pe=%b h=%0d v=%0d hs=%b vs=%b vid=%b ls=%b fs=%b want pe=%b h=%0d v=%0d hs=%b vs=%b vid=%b ls=%b fs=%b",
                     nm, ncyc, act.pe, act.h, act.v, act.hs, act.vs, act.vid, act.ls, act.fs,
                     exp.pe, exp.h, exp.v, exp.hs, exp.vs, exp.vid, exp.ls, exp.fs);
        end
    endtask

    task automatic lit(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic goto(input int target);
        int guard = 0;
        while (ncyc != target && guard < 60000) begin
            @(negedge clk);
            guard++;
        end
        lit("reach_cycle", ncyc, target);
    endtask

    always @(negedge clk) begin
        chk("model_A", m_a(ncyc), oa);
        chk("model_B", m_b(ncyc), ob);
        chk("model_C", m_c(ncyc), oc);
        chk("model_E", m_e(ncyc), oe);
        if (phase == 0 && rst_n) begin
            if (ncyc >= 2 && ncyc < 2082) begin
                if (hs_a)  a_hs_cnt++;
                if (vid_a) a_vid_cnt++;
            end
            if (ncyc >= 2 && ncyc < 155 && !vs_b) b_vs_cnt++;
        end
    end

    initial begin
        repeat (5) @(negedge clk);
        lit("rst_A_h", int'(h_a), 0);
        lit("rst_A_hs", int'(hs_a), 0);
        lit("rst_B_hs", int'(hs_b), 1);
        lit("rst_A_fs", int'(fs_a), 0);
        #2 rst_n = 1'b1;

        goto(1);
        lit("first_pix_en", int'(pe_a), 1);
        lit("first_fs_early", int'(fs_a), 0);
        goto(2);
        lit("first_fs", int'(fs_a), 1);
        lit("first_ls", int'(ls_a), 1);
        lit("first_vid", int'(vid_a), 1);
        lit("first_h", int'(h_a), 0);
        goto(154);
        lit("B_last_h", int'(h_b), 16);
        lit("B_last_v", int'(v_b), 8);
        goto(155);
        lit("B_wrap_hv", int'({h_b, v_b}), 0);
        lit("B_wrap_fs", int'(fs_b), 1);
        lit("B_wrap_ls", int'(ls_b), 1);
        lit("B_vs_clks", b_vs_cnt, 34);
        goto(2082);
        lit("A_hs_clks", a_hs_cnt, 240);
        lit("A_vid_clks", a_vid_cnt, 1600);
        goto(4164);
        lit("C_line_h", int'(h_c), 0);
        lit("C_line_v", int'(v_c), 1);
        lit("C_line_ls", int'(ls_c), 1);
        goto(22880);
        lit("A_pre_wrap_h", int'(h_a), 1039);
        lit("A_pre_wrap_v", int'(v_a), 10);
        goto(22882);
        lit("A_wrap_h", int'(h_a), 0);
        lit("A_wrap_v", int'(v_a), 11);
        lit("A_wrap_ls", int'(ls_a), 1);
        lit("A_wrap_fs", int'(fs_a), 0);
        goto(22883);
        lit("A_ls_one_clk", int'(ls_a), 0);

        phase = 1;
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(3000, 20)) @(negedge clk);
            #($urandom_range(3, 1));
            rst_n = 1'b0;
            #1;
            chk("async_A", m_a(0), oa);
            chk("async_B", m_b(0), ob);
            chk("async_C", m_c(0), oc);
            chk("async_E", m_e(0), oe);
            lit("async_A_hv", int'({h_a, v_a}), 0);
            repeat ($urandom_range(4, 1)) @(negedge clk);
            #2 rst_n = 1'b1;
            goto(2);
            lit("rerun_fs", int'(fs_a), 1);
            lit("rerun_vid", int'(vid_a), 1);
        end
        repeat (200) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- CLK_DIV, 2, system clocks per pixel (1..16).
- H_VIS, 800, visible pixels per line.
- H_FP, 56, horizontal front porch.
- H_SYNC, 120, horizontal sync width.
- H_BP, 64, horizontal back porch.
- V_VIS, 600, visible lines.
- V_FP, 37, vertical front porch.
- V_SYNC, 6, vertical sync width.
- V_BP, 23, vertical back porch.
- SYNC_POL, 1, sync active level (1 = active-high).
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, system clock, 100 MHz nominal.
- rst_n, in, 1, reset; one clock; reset is asynchronous and active-low.
- pix_en, out, 1, one-clk pixel strobe.
- Hcnt, out, 11, horizontal pixel counter.
- Vcnt, out, 11, vertical line counter.
- hs, out, 1, horizontal sync.
- vs, out, 1, vertical sync.
- video_on, out, 1, current pixel is visible.
- line_start, out, 1, one-clk pulse at the start of each line.
- frame_start, out, 1, one-clk pulse at the start of each frame.

Function
REQ-003 Define H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP (1040) and V_TOTAL = V_VIS+V_FP+V_SYNC+V_BP (666).
REQ-004 Elaboration SHALL fail if H_TOTAL > 2048, V_TOTAL > 2048, or CLK_DIV is outside 1..16.
REQ-005 Divider counter div SHALL count 0..CLK_DIV-1 and wrap.
REQ-006 pix_en SHALL be registered and high for exactly one clk when div = CLK_DIV-1. With CLK_DIV = 1, pix_en SHALL be constantly high after reset.
REQ-007 Hcnt and Vcnt SHALL change only on clk edges where pix_en = 1.
REQ-008 On a pix_en edge, Hcnt SHALL increment. At H_TOTAL-1, Hcnt SHALL wrap to 0 and Vcnt SHALL increment in the same edge.
REQ-009 At Hcnt = H_TOTAL-1 and Vcnt = V_TOTAL-1, both counters SHALL wrap to 0 on the same edge.
REQ-010 Hcnt and Vcnt SHALL be unsigned 11-bit registers.
REQ-011 A signed downstream consumer reads Hcnt >= 1024 as negative. This SHALL occur only while video_on = 0.
REQ-012 hs SHALL be at SYNC_POL exactly when H_VIS+H_FP <= Hcnt <= H_VIS+H_FP+H_SYNC-1 (856..975), and at ~SYNC_POL otherwise.
REQ-013 vs SHALL be at SYNC_POL exactly when V_VIS+V_FP <= Vcnt <= V_VIS+V_FP+V_SYNC-1 (637..642), and at ~SYNC_POL otherwise.
REQ-014 hs and vs SHALL be registered so that they change on the same edge as the counter value they decode.
REQ-015 video_on SHALL equal (Hcnt < H_VIS) && (Vcnt < V_VIS) && started. It SHALL be registered and aligned with the counters.
REQ-016 started SHALL be an internal flag, cleared by reset and set on the first pix_en edge.
REQ-017 line_start SHALL be high for the one clk following any edge on which Hcnt became 0.
REQ-018 frame_start SHALL be high for the one clk following any edge on which Hcnt and Vcnt both became 0. When it fires, line_start SHALL also be high.
REQ-019 The first frame after reset SHALL assert line_start and frame_start on the first pix_en edge, with counters held at 0,0.
REQ-020 Outputs SHALL contain no combinational path from rst_n other than the asynchronous clear.

Reset
REQ-021 While rst_n = 0, the block SHALL drive: div = 0, Hcnt = 0, Vcnt = 0, started = 0, pix_en = 0, video_on = 0, line_start = 0, frame_start = 0, hs = ~SYNC_POL, vs = ~SYNC_POL.
REQ-022 Asserting rst_n mid-frame SHALL clear all state immediately, without waiting for a clock.
REQ-023 After rst_n deasserts, the first pix_en SHALL occur CLK_DIV clks later. Timing SHALL then restart from REQ-019.

Verification
REQ-024 Reset check: hold rst_n low for 5 clks. Required: every output at its REQ-021 value. Release rst_n: pix_en first high on clk 2 (CLK_DIV = 2); Hcnt = 0, Vcnt = 0, frame_start = 1, video_on = 1.
REQ-025 Line wrap: run to Hcnt = 1039, Vcnt = 10. Required: next pix_en edge gives Hcnt = 0, Vcnt = 11, line_start = 1 for one clk, frame_start = 0.
REQ-026 hs window: scan one line. Required: hs = 1 for Hcnt 856..975 only (120 pixels = 240 clks); video_on = 0 for Hcnt 800..1039.
REQ-027 Frame wrap: run to Hcnt = 1039, Vcnt = 665. Required: next pix_en edge gives 0,0, with frame_start = 1 and line_start = 1; vs = 1 for exactly Vcnt 637..642 (6 × 1040 pixels).
REQ-028 Reset mid-frame: pull rst_n low asynchronously at Hcnt = 500, Vcnt = 300, between clock edges. Required: Hcnt = 0, Vcnt = 0, hs = 0, vs = 0 before the next clk edge. After release, REQ-024 behaviour repeats.
REQ-029 Divider variant: with CLK_DIV = 1, pix_en SHALL stay high and Hcnt SHALL advance every clk. With CLK_DIV = 4, pix_en period SHALL be 4 clks and each line SHALL take 4160 clks.
